// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizing for the fetch/data memory arbiter.
// Holds the response FSM encoding and the width/limit defaults.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int STARVE_CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } resp_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side bus bundle for mem_arbiter.
// slave = arbiter view; master = requesters plus RAM environment.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_en;
    logic [DATA_W/8-1:0]   mem_wea;
    logic [ADDR_W-1:0]     mem_addra;
    logic [DATA_W-1:0]     mem_dina;
    logic [DATA_W-1:0]     mem_douta;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_wea, mem_addra, mem_dina,
        input  mem_douta
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_wea, mem_addra, mem_dina,
        output mem_douta
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive fetch conflict losses, saturating at LIMIT; at_limit is registered state.
// Latency: at_limit reflects losses up to the previous cycle; no backpressure.
module mem_arb_starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic conflict_lost,
    input  logic clear,
    output logic at_limit
);

    localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (conflict_lost && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto a 1-cycle single-port RAM: combinational grant, rvalid one cycle later.
// No buffering; losers hold their request. Optional counters under MEM_ARBITER_STATS_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic           clka,
    input  logic           rst,
    mem_arbiter_if.slave   bus
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [31:0]    stat_if_gnt,
    output logic [31:0]    stat_d_gnt,
    output logic [31:0]    stat_conflict
`endif
);

    resp_state_e           state_q, state_d;
    logic                  conflict;
    logic                  at_limit;
    logic                  if_win;
    logic                  d_win;
    logic [ADDR_W-1:0]     addr_sel;
    logic [DATA_W/8-1:0]   wea_sel;

    assign conflict = bus.if_req & bus.d_req;

    // Grants are forced low while reset is held, since they are combinational.
    assign if_win = rst & bus.if_req & (~bus.d_req | at_limit);
    assign d_win  = rst & bus.d_req & ~if_win;

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk           (clka),
        .rst_n         (rst),
        .conflict_lost (conflict & ~if_win),
        .clear         (if_win | ~bus.if_req),
        .at_limit      (at_limit)
    );

    always_comb begin
        state_d  = IDLE;
        addr_sel = bus.d_addr;
        wea_sel  = '0;
        if (if_win) begin
            state_d  = RESP_IF;
            addr_sel = bus.if_addr;
        end else if (d_win) begin
            if (bus.d_we) begin
                wea_sel = bus.d_wstrb;
            end else begin
                state_d = RESP_D;
            end
        end
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.if_gnt    = if_win;
    assign bus.d_gnt     = d_win;
    assign bus.mem_en    = if_win | d_win;
    assign bus.mem_wea   = wea_sel;
    assign bus.mem_addra = addr_sel;
    assign bus.mem_dina  = bus.d_wdata;

    assign bus.if_rvalid = (state_q == RESP_IF);
    assign bus.d_rvalid  = (state_q == RESP_D);
    assign bus.if_rdata  = bus.mem_douta;
    assign bus.d_rdata   = bus.mem_douta;

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] stat_if_gnt_q, stat_d_gnt_q, stat_conflict_q;

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            stat_if_gnt_q   <= '0;
            stat_d_gnt_q    <= '0;
            stat_conflict_q <= '0;
        end else begin
            if (if_win)   stat_if_gnt_q   <= stat_if_gnt_q + 32'd1;
            if (d_win)    stat_d_gnt_q    <= stat_d_gnt_q + 32'd1;
            if (conflict) stat_conflict_q <= stat_conflict_q + 32'd1;
        end
    end

    assign stat_if_gnt   = stat_if_gnt_q;
    assign stat_d_gnt    = stat_d_gnt_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reference arbitration model plus read-data scoreboard.
// Contains a 1-cycle RAM stub driven from the DUT's captured memory outputs.
module tb_mem_arbiter;

    localparam int LIM = 4;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } sb_t;

    logic clka;
    logic rst;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] stat_if_gnt, stat_d_gnt, stat_conflict;
`endif

    mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .stat_if_gnt   (stat_if_gnt),
        .stat_d_gnt    (stat_d_gnt),
        .stat_conflict (stat_conflict)
`endif
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    int          n_checks = 0;
    int          n_errors = 0;
    int          mcnt     = 0;
    logic        exp_if_rv = 1'b0;
    logic        exp_d_rv  = 1'b0;
    sb_t         sb[$];
    logic [31:0] ref_mem [256];
    logic [31:0] ram     [256];

    logic        ram_en   = 1'b0;
    logic [3:0]  ram_we   = 4'h0;
    logic [7:0]  ram_idx  = 8'h0;
    logic [31:0] ram_din  = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // RAM stub: read-first, byte-enabled, executes the access captured on the previous cycle.
    task automatic tick();
        @(posedge clka);
        if (ram_en) begin
            bus.mem_douta = ram[ram_idx];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) ram[ram_idx][8*b +: 8] = ram_din[8*b +: 8];
            end
        end
        ram_en = 1'b0;
    endtask

    task automatic set_idle();
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.d_wstrb = 4'h0;
    endtask

    task automatic drive_cycle(input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dd, input logic [3:0] ds);
        logic pred_if, pred_d;
        sb_t  e;
        tick();
        #1;
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dd;
        bus.d_wstrb = ds;
        pred_if = ir && (!dr || mcnt == LIM);
        pred_d  = dr && !pred_if;
        @(negedge clka);
        check_eq("if_gnt", bus.if_gnt, pred_if);
        check_eq("d_gnt", bus.d_gnt, pred_d);
        check_eq("mem_en", bus.mem_en, pred_if | pred_d);
        check_eq("mem_wea", bus.mem_wea, (pred_d && dw) ? ds : 4'h0);
        if (pred_if)      check_eq("mem_addra_if", bus.mem_addra, ia);
        else if (pred_d)  check_eq("mem_addra_d", bus.mem_addra, da);
        if (pred_d && dw) check_eq("mem_dina", bus.mem_dina, dd);
        check_eq("if_rvalid", bus.if_rvalid, exp_if_rv);
        check_eq("d_rvalid", bus.d_rvalid, exp_d_rv);
        if (bus.if_rvalid || bus.d_rvalid) begin
            if (sb.size() == 0) begin
                check_eq("sb_nonempty", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check_eq("rd_port", bus.d_rvalid, e.port);
                check_eq("rdata", bus.d_rvalid ? bus.d_rdata : bus.if_rdata, e.data);
            end
        end
        ram_en  = bus.mem_en;
        ram_we  = bus.mem_wea;
        ram_idx = bus.mem_addra[9:2];
        ram_din = bus.mem_dina;
        exp_if_rv = pred_if;
        exp_d_rv  = pred_d && !dw;
        if (pred_if) sb.push_back('{1'b0, ref_mem[ia[9:2]]});
        if (pred_d && !dw) sb.push_back('{1'b1, ref_mem[da[9:2]]});
        if (pred_d && dw) begin
            for (int b = 0; b < 4; b++) begin
                if (ds[b]) ref_mem[da[9:2]][8*b +: 8] = dd[8*b +: 8];
            end
        end
        if (pred_if || !ir) mcnt = 0;
        else if (dr && mcnt < LIM) mcnt++;
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic apply_reset();
        tick();
        #1;
        rst = 1'b0;
        bus.if_req  = 1'b1;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_wstrb = 4'hF;
        #1;
        check_eq("rst_if_gnt", bus.if_gnt, 1'b0);
        check_eq("rst_d_gnt", bus.d_gnt, 1'b0);
        check_eq("rst_mem_en", bus.mem_en, 1'b0);
        check_eq("rst_mem_wea", bus.mem_wea, 4'h0);
        check_eq("rst_if_rvalid", bus.if_rvalid, 1'b0);
        check_eq("rst_d_rvalid", bus.d_rvalid, 1'b0);
`ifdef MEM_ARBITER_STATS_EN
        check_eq("rst_stat_if", stat_if_gnt, 32'd0);
        check_eq("rst_stat_d", stat_d_gnt, 32'd0);
        check_eq("rst_stat_conf", stat_conflict, 32'd0);
`endif
        repeat (2) tick();
        #1;
        set_idle();
        rst = 1'b1;
        mcnt = 0;
        exp_if_rv = 1'b0;
        exp_d_rv  = 1'b0;
        sb.delete();
        @(negedge clka);
        check_eq("post_rst_if_rvalid", bus.if_rvalid, 1'b0);
        check_eq("post_rst_d_rvalid", bus.d_rvalid, 1'b0);
        ram_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        set_idle();
        bus.mem_douta = 32'h0;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'hC0DE0000 + i;
            ref_mem[i] = 32'hC0DE0000 + i;
        end
        ram[32]     = 32'h11223344;
        ref_mem[32] = 32'h11223344;

        apply_reset();

        // Back-to-back fetches
        drive_cycle(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_cycle(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_cycle(1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle_cycle();

        // Full write then readback
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        idle_cycle();

        // Partial write then readback
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hAAAABBBB, 4'h3);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
        idle_cycle();
        check_eq("partial_ref", ref_mem[32], 32'h1122BBBB);

        // Sustained conflict from a fresh reset: 4 data wins then 1 fetch, twice
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 32'h100 + 32'(i*4), 1'b1, 1'b0, 32'h200 + 32'(i*4), 32'h0, 4'h0);
        end
        idle_cycle();
`ifdef MEM_ARBITER_STATS_EN
        check_eq("stat_conflict", stat_conflict, 32'd10);
        check_eq("stat_d_gnt", stat_d_gnt, 32'd8);
        check_eq("stat_if_gnt", stat_if_gnt, 32'd2);
`endif

        // Random mixed traffic
        for (int i = 0; i < 60; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        32'($urandom_range(0, 255)) << 2, $urandom, 4'($urandom_range(0, 15)));
        end
        idle_cycle();

        // Starvation count must not survive reset
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        end
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        end
        idle_cycle();

        // Reset the cycle after a fetch grant: response is dropped
        drive_cycle(1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        apply_reset();
        idle_cycle();
        drive_cycle(1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle_cycle();
        check_eq("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the address width of all ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the data width of all ports; the byte-strobe width SHALL be DATA_W/8.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, giving the number of consecutive lost conflicts after which fetch wins; legal range 1..15.
REQ-004 The block SHALL have port clka, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port if_req, input, 1 bit: the instruction-fetch read request.
REQ-007 The block SHALL have port if_addr, input, ADDR_W bits: the fetch address.
REQ-008 The block SHALL have ports if_gnt, if_rvalid (outputs, 1 bit each) and if_rdata (output, DATA_W bits): fetch grant, response valid and response data.
REQ-009 The block SHALL have inputs d_req (1), d_we (1), d_addr (ADDR_W), d_wdata (DATA_W) and d_wstrb (DATA_W/8): the data-port request.
REQ-010 The block SHALL have ports d_gnt, d_rvalid (outputs, 1 bit each) and d_rdata (output, DATA_W bits).
REQ-011 The block SHALL have outputs mem_en (1), mem_wea (DATA_W/8), mem_addra (ADDR_W) and mem_dina (DATA_W), plus input mem_douta (DATA_W), toward the single-port synchronous RAM with 1-cycle read latency.

Function
REQ-012 At most one requester SHALL be granted per cycle; the grant is combinational in the request cycle.
REQ-013 The granted request's fields SHALL drive mem_addra and mem_dina in the same cycle, with mem_en=1; mem_en SHALL be 0 when no grant is given.
REQ-014 mem_wea SHALL equal d_wstrb for a granted data write and 0 otherwise; fetch SHALL never write.
REQ-015 On a conflict (if_req and d_req both high), data SHALL win unless starve_cnt==STARVE_LIMIT, in which case fetch SHALL win.
REQ-016 starve_cnt SHALL increment on each cycle in which fetch loses a conflict, saturate at STARVE_LIMIT, and clear on any fetch grant or on any cycle with if_req=0.
REQ-017 The response FSM SHALL have states IDLE, RESP_IF and RESP_D: the next state is RESP_IF after a fetch grant, RESP_D after a granted data read, and IDLE otherwise (including after a write).
REQ-018 if_rvalid SHALL be 1 exactly in state RESP_IF and d_rvalid exactly in state RESP_D, i.e. one cycle after the grant.
REQ-019 if_rdata and d_rdata SHALL both equal mem_douta; they are meaningful only when the matching rvalid is high.
REQ-020 A response and a new grant SHALL coexist in the same cycle, giving back-to-back throughput of 1 access per cycle.
REQ-021 A requester SHALL hold its request fields stable while req=1 and gnt=0; the block SHALL perform no buffering and no forwarding of write data.

Reset
REQ-022 While rst=0, the state SHALL be IDLE, starve_cnt SHALL be 0, and all gnt, rvalid, mem_en and mem_wea outputs SHALL be 0.
REQ-023 An outstanding response SHALL be discarded when reset is asserted; no rvalid SHALL appear in the first cycle after reset is released.

Configuration
REQ-024 With macro MEM_ARBITER_STATS_EN defined, the block SHALL add 32-bit outputs stat_if_gnt, stat_d_gnt and stat_conflict, which count fetch grants, data grants and conflict cycles, wrap on overflow, and reset to 0.
REQ-025 Without MEM_ARBITER_STATS_EN, those ports and counters SHALL be absent, and the remaining behaviour SHALL be unchanged.

Structure
REQ-026 Package mem_arbiter_pkg SHALL hold the FSM state enum (IDLE, RESP_IF, RESP_D) and the default width and limit constants.
REQ-027 The starvation counter SHALL be the sub-module mem_arb_starve_ctr, with inputs conflict_lost and clear, and output at_limit.

Verification
REQ-028 Fetch only: if_req=1, if_addr=0x00, 0x04, 0x08 on consecutive cycles -> if_gnt=1 in each cycle, and if_rvalid=1 on cycles 2-4 carrying the RAM words at those addresses.
REQ-029 Data write then read: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_wstrb=0xF, then a read of 0x40 -> mem_wea=0xF in cycle 1, and d_rvalid=1 with d_rdata=0xDEADBEEF in cycle 3.
REQ-030 Sustained conflict: if_req and d_req held at 1 with STARVE_LIMIT=4 -> data granted for 4 cycles, fetch granted in the 5th, and the pattern repeats.
REQ-031 Partial write: d_wstrb=0x3 to address 0x80 previously holding 0x11223344 with d_wdata=0xAAAABBBB -> a readback of 0x80 returns 0x1122BBBB.
REQ-032 Reset mid-operation: rst asserted in the cycle after a fetch grant -> if_rvalid=0 and mem_en=0 immediately, and after release starve_cnt=0 and no stray rvalid appears.
REQ-033 With MEM_ARBITER_STATS_EN defined, 10 conflict cycles -> stat_conflict=10, stat_d_gnt=8 and stat_if_gnt=2.
